// File: rtl/bp_mem_noc_responder.sv
// bp_mem_noc_responder: memory-side mem NoC endpoint serving wormhole rd/wr packets from a local word array
// Ports: clk_i, reset_n_i (async, active-low), my_cord_i (own cord for resp src_cord),
//   mem_cmd_link_i/o (cmd flits in, ready_and back), mem_resp_link_o/i (resp flits out, ready_and back),
//   rd_count_o/wr_count_o (served packet counters).
// Optional feature: define BP_MEM_NOC_RESPONDER_STATS_EN to enable the counters; otherwise they read 0.
// Link layout: {v, ready_and_rev, data[flit_width_p-1:0]}.
module bp_mem_noc_responder #(
  parameter int flit_width_p  = 64,
  parameter int cord_width_p  = 8,
  parameter int len_width_p   = 4,
  parameter int mem_els_p     = 256,
  parameter int link_width_lp = flit_width_p + 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [cord_width_p-1:0]  my_cord_i,
  input  logic [link_width_lp-1:0] mem_cmd_link_i,
  output logic [link_width_lp-1:0] mem_cmd_link_o,
  output logic [link_width_lp-1:0] mem_resp_link_o,
  input  logic [link_width_lp-1:0] mem_resp_link_i,
  output logic [15:0]              rd_count_o,
  output logic [15:0]              wr_count_o
);
  localparam int lg_lp = $clog2(mem_els_p);
  typedef enum logic [1:0] {e_ready, e_wdata, e_resp_hdr, e_rdata} state_e;
  state_e r_state, w_state_n;
  logic                    r_cmd_rdy, r_resp_v, r_err;
  logic [flit_width_p-1:0] r_resp_data;
  logic [flit_width_p-1:0] r_mem [mem_els_p];
  logic [7:0]              r_src;
  logic [1:0]              r_op;
  logic [31:0]             r_addr;
  logic [2:0]              r_bm1;
  logic [len_width_p-1:0]  r_len, r_cnt;
  logic [lg_lp-1:0]        r_idx, w_idx_inc;
  logic                    w_cmd_v, w_resp_rdy, w_cmd_fire, w_resp_fire;
  logic [flit_width_p-1:0] w_cmd_d;
  logic [3:0]              w_in_len, w_in_beats, w_h_len;
  logic [7:0]              w_in_src, w_h_src;
  logic [1:0]              w_in_op, w_h_op;
  logic [31:0]             w_in_addr, w_h_addr;
  logic [2:0]              w_in_bm1, w_h_bm1;
  logic                    w_in_err, w_h_err, w_sel_in;
  logic [63:0]             w_rsp_hdr;
  logic                    w_last_w, w_last_r, w_cmd_rdy_n, w_load_hdr, w_wr_en;
  logic                    w_unused;
  assign w_cmd_v     = mem_cmd_link_i[flit_width_p+1];
  assign w_cmd_d     = mem_cmd_link_i[flit_width_p-1:0];
  assign w_resp_rdy  = mem_resp_link_i[flit_width_p];
  assign w_unused    = ^{mem_cmd_link_i, mem_resp_link_i};
  assign w_cmd_fire  = w_cmd_v & r_cmd_rdy;
  assign w_resp_fire = r_resp_v & w_resp_rdy;
  assign mem_cmd_link_o  = {1'b0, r_cmd_rdy, {flit_width_p{1'b0}}};
  assign mem_resp_link_o = {r_resp_v, 1'b0, r_resp_data};
  assign w_in_len   = w_cmd_d[11:8];
  assign w_in_src   = w_cmd_d[19:12];
  assign w_in_op    = w_cmd_d[21:20];
  assign w_in_addr  = w_cmd_d[53:22];
  assign w_in_bm1   = w_cmd_d[56:54];
  assign w_in_beats = {1'b0, w_in_bm1} + 4'd1;
  assign w_in_err   = w_in_op[1] | (w_in_op == 2'b01 && w_in_len != w_in_beats)
                    | (w_in_op == 2'b00 && w_in_len != 4'd0);
  // A zero-length command answers in the same cycle its header lands, before the fields are latched
  assign w_sel_in  = r_state == e_ready;
  assign w_h_src   = w_sel_in ? w_in_src  : r_src;
  assign w_h_op    = w_sel_in ? w_in_op   : r_op;
  assign w_h_addr  = w_sel_in ? w_in_addr : r_addr;
  assign w_h_bm1   = w_sel_in ? w_in_bm1  : r_bm1;
  assign w_h_err   = w_sel_in ? w_in_err  : r_err;
  assign w_h_len   = (w_h_op == 2'b00 && !w_h_err) ? {1'b0, w_h_bm1} + 4'd1 : 4'd0;
  assign w_rsp_hdr = {w_h_err, 6'b0, w_h_bm1, w_h_addr, w_h_op, my_cord_i, w_h_len, w_h_src};
  assign w_idx_inc = r_idx + lg_lp'(1);
  assign w_last_w  = (r_cnt + len_width_p'(1)) == r_len;
  assign w_last_r  = r_cnt == len_width_p'(r_bm1);
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_state <= e_ready;
    else r_state <= w_state_n;
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      e_ready:    if (w_cmd_fire) w_state_n = (w_in_len != 4'd0) ? e_wdata : e_resp_hdr;
      e_wdata:    if (w_cmd_fire && w_last_w) w_state_n = e_resp_hdr;
      e_resp_hdr: if (w_resp_fire) w_state_n = (r_op == 2'b00 && !r_err) ? e_rdata : e_ready;
      default:    if (w_resp_fire && w_last_r) w_state_n = e_ready;
    endcase
  end
  always_comb begin
    w_cmd_rdy_n = w_state_n == e_ready || w_state_n == e_wdata;
    w_load_hdr  = w_state_n == e_resp_hdr && r_state != e_resp_hdr;
    w_wr_en     = r_state == e_wdata && w_cmd_fire && !r_err;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_cmd_rdy   <= 1'b0;
      r_resp_v    <= 1'b0;
      r_resp_data <= '0;
      r_src       <= '0;
      r_op        <= '0;
      r_addr      <= '0;
      r_bm1       <= '0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
    end else begin
      r_cmd_rdy <= w_cmd_rdy_n;
      if (r_state == e_ready && w_cmd_fire) begin
        r_src  <= w_in_src;
        r_op   <= w_in_op;
        r_addr <= w_in_addr;
        r_bm1  <= w_in_bm1;
        r_len  <= w_in_len;
        r_err  <= w_in_err;
        r_cnt  <= '0;
        r_idx  <= w_cmd_d[25 +: lg_lp];
      end else if ((r_state == e_wdata && w_cmd_fire) || (r_state == e_rdata && w_resp_fire)) begin
        r_cnt <= r_cnt + len_width_p'(1);
        r_idx <= w_idx_inc;
      end
      if (w_load_hdr) begin
        r_resp_v    <= 1'b1;
        r_resp_data <= flit_width_p'(w_rsp_hdr);
      end else if (w_resp_fire) begin
        r_resp_v    <= w_state_n == e_rdata;
        r_resp_data <= (r_state == e_rdata) ? r_mem[w_idx_inc] : r_mem[r_idx];
      end
    end
  always_ff @(posedge clk_i)
    if (w_wr_en) r_mem[r_idx] <= w_cmd_d;
`ifdef BP_MEM_NOC_RESPONDER_STATS_EN
  logic [15:0] r_rd_cnt, r_wr_cnt;
  logic        w_good_hdr;
  assign w_good_hdr = r_state == e_resp_hdr && w_resp_fire && !r_err;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_good_hdr) begin
      if (r_op == 2'b00 && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (r_op == 2'b01 && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  assign rd_count_o = r_rd_cnt;
  assign wr_count_o = r_wr_cnt;
`else
  assign rd_count_o = '0;
  assign wr_count_o = '0;
`endif
endmodule

// File: tb/tb_bp_mem_noc_responder.sv
// tb_bp_mem_noc_responder: scoreboard bench with a word-array reference model of the mem responder
module tb_bp_mem_noc_responder;
  localparam int W = 64;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] my_cord = 8'h3C;
  logic cmd_v = 1'b0, resp_rdy = 1'b0;
  logic [W-1:0] cmd_d = '0;
  logic [W+1:0] cmd_link_i, cmd_link_o, resp_link_o, resp_link_i;
  logic [15:0] rd_cnt, wr_cnt;
  logic cmd_rdy, resp_v;
  logic [W-1:0] resp_d;
  assign cmd_link_i  = {cmd_v, 1'b0, cmd_d};
  assign resp_link_i = {1'b0, resp_rdy, {W{1'b0}}};
  assign cmd_rdy = cmd_link_o[W];
  assign resp_v  = resp_link_o[W+1];
  assign resp_d  = resp_link_o[W-1:0];
  bp_mem_noc_responder dut (
    .clk_i(clk), .reset_n_i(reset_n), .my_cord_i(my_cord),
    .mem_cmd_link_i(cmd_link_i), .mem_cmd_link_o(cmd_link_o),
    .mem_resp_link_o(resp_link_o), .mem_resp_link_i(resp_link_i),
    .rd_count_o(rd_cnt), .wr_count_o(wr_cnt));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int rd_m = 0, wr_m = 0;
  int rdy_mode = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem_m [256];
  logic [W-1:0] pay [16];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] mk(input logic [7:0] dst, input logic [3:0] len, input logic [7:0] src,
                                     input logic [1:0] op, input logic [31:0] addr, input logic [2:0] bm1,
                                     input logic err);
    return {err, 6'b0, bm1, addr, op, src, len, dst};
  endfunction
  // resp ready: 0 = random, 1 = held low, 2 = held high
  initial forever begin
    @(posedge clk);
    #1;
    resp_rdy = rdy_mode == 1 ? 1'b0 : rdy_mode == 2 ? 1'b1 : ($urandom_range(3) != 0);
  end
  initial forever begin
    @(negedge clk);
    if (resp_v && resp_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got %h expected no flit", resp_d);
      end else chk("resp_flit", resp_d, exp_q.pop_front());
    end
  end
  task automatic send(input logic [63:0] d);
    int t;
    t = 0;
    cmd_v = 1'b1;
    cmd_d = d;
    @(negedge clk);
    while (!cmd_rdy) begin
      t++;
      if (t > 5000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cmd_ready_timeout: got ready=0 expected ready=1");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "cmd link stuck");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cmd_v = 1'b0;
  endtask
  task automatic rand_pay();
    for (int i = 0; i < 16; i++) pay[i] = {$urandom, $urandom};
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [2:0] bm1, input logic [3:0] len);
    int beats, idx;
    logic err;
    logic [7:0] rsrc;
    beats = int'(bm1) + 1;
    idx = int'(addr[10:3]);
    err = op > 2'd1 || (op == 2'd1 && int'(len) != beats) || (op == 2'd0 && len != 4'd0);
    rsrc = 8'($urandom);
    exp_q.push_back(mk(rsrc, (op == 2'd0 && !err) ? 4'(beats) : 4'd0, my_cord, op, addr, bm1, err));
    if (op == 2'd0 && !err)
      for (int i = 0; i < beats; i++) exp_q.push_back(mem_m[(idx + i) % 256]);
    if (!err) begin
      if (op == 2'd0) rd_m++;
      else wr_m++;
    end
    send(mk(8'($urandom), len, rsrc, op, addr, bm1, 1'b0));
    for (int i = 0; i < int'(len); i++) begin
      if (!err) mem_m[(idx + i) % 256] = pay[i];
      send(pay[i]);
    end
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d flits outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic chk_stats();
`ifdef BP_MEM_NOC_RESPONDER_STATS_EN
    chk("rd_count", 64'(rd_cnt), 64'(rd_m));
    chk("wr_count", 64'(wr_cnt), 64'(wr_m));
`else
    chk("rd_count_off", 64'(rd_cnt), 64'd0);
    chk("wr_count_off", 64'(wr_cnt), 64'd0);
`endif
  endtask
  initial begin
    logic [63:0] d0;
    int t, r;
    logic [2:0] bm1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 64'(cmd_rdy), 64'd0);
    chk("reset_resp_v", 64'(resp_v), 64'd0);
    chk("reset_rd_count", 64'(rd_cnt), 64'd0);
    chk("reset_wr_count", 64'(wr_cnt), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(cmd_rdy), 64'd1);
    rdy_mode = 2;
    for (int k = 0; k < 32; k++) begin
      rand_pay();
      issue(2'd1, 32'(k * 64), 3'd7, 4'd8);
    end
    wait_idle();
    rand_pay();
    pay[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    pay[1] = 64'h5A5A_5A5A_5A5A_5A5A;
    issue(2'd1, 32'h40, 3'd1, 4'd2);
    issue(2'd0, 32'h40, 3'd1, 4'd0);
    rand_pay();
    issue(2'd1, 32'(255 * 8), 3'd1, 4'd2);
    issue(2'd0, 32'(255 * 8), 3'd1, 4'd0);
    rdy_mode = 0;
    rand_pay();
    issue(2'd3, 32'h40, 3'd1, 4'd1);
    issue(2'd0, 32'h40, 3'd1, 4'd3);
    issue(2'd1, 32'h80, 3'd3, 4'd2);
    issue(2'd0, 32'h40, 3'd1, 4'd0);
    issue(2'd0, 32'h80, 3'd3, 4'd0);
    wait_idle();
    rdy_mode = 1;
    @(posedge clk);
    #1;
    issue(2'd0, 32'h100, 3'd3, 4'd0);
    t = 0;
    while (!resp_v && t < 20) begin
      @(negedge clk);
      t++;
    end
    d0 = resp_d;
    chk("bp_first_v", 64'(resp_v), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_v_hold", 64'(resp_v), 64'd1);
      chk("bp_data_hold", resp_d, d0);
      chk("bp_cmd_ready", 64'(cmd_rdy), 64'd0);
    end
    rdy_mode = 0;
    wait_idle();
    rand_pay();
    send(mk(8'h01, 4'd4, 8'h22, 2'd1, 32'h200, 3'd3, 1'b0));
    send(pay[0]);
    mem_m[64] = pay[0];
    reset_n = 1'b0;
    #1;
    chk("rst_resp_v", 64'(resp_v), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_rdy), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd_m = 0;
    wr_m = 0;
    @(posedge clk);
    #1;
    issue(2'd0, 32'h200, 3'd3, 4'd0);
    rand_pay();
    issue(2'd1, 32'h300, 3'd2, 4'd3);
    issue(2'd0, 32'h300, 3'd2, 4'd0);
    rand_pay();
    issue(2'd1, 32'h308, 3'd0, 4'd1);
    issue(2'd2, 32'h300, 3'd0, 4'd0);
    issue(2'd0, 32'h200, 3'd0, 4'd0);
    wait_idle();
    chk_stats();
    for (int n = 0; n < 80; n++) begin
      rand_pay();
      r = $urandom_range(9);
      bm1 = 3'($urandom_range(7));
      if (r < 4) issue(2'd0, $urandom, bm1, 4'd0);
      else if (r < 8) issue(2'd1, $urandom, bm1, 4'(bm1) + 4'd1);
      else if (r == 8) issue(2'd0, $urandom, bm1, 4'($urandom_range(1, 3)));
      else issue(2'($urandom_range(2, 3)), $urandom, bm1, 4'($urandom_range(0, 3)));
    end
    wait_idle();
    chk_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
